// File: rtl/cut_sequencer.sv
// Cutter job sequencer: feeds len_i steps on a 4-phase stepper, then runs one cut handshake per
// piece, repeating num_i times. Reports progress, completion and cut-handshake timeout.
module cut_sequencer #(
    parameter int STEP_PERIOD = 50000,
    parameter int LEN_W       = 16,
    parameter int CNT_W       = 8,
    parameter int CUT_TIMEOUT = 50000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [CNT_W-1:0] num_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] pieces_o,
    output logic [3:0]       feed_phase_o,
    output logic             cut_o,
    input  logic             cut_end_i
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FEED    = 3'd1,
        S_CUT     = 3'd2,
        S_CUT_REL = 3'd3,
        S_DONE    = 3'd4,
        S_ERR     = 3'd5
    } state_e;

    localparam int DIV_W = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
    localparam int TMO_W = $clog2(CUT_TIMEOUT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(STEP_PERIOD - 1);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(CUT_TIMEOUT - 1);
    localparam logic [3:0]       PHASE_FIRST = 4'b0001;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [CNT_W-1:0]   pieces_q, pieces_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [LEN_W-1:0]   step_q, step_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [3:0]         phase_q, phase_d;
    logic               cut_q, cut_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [CNT_W:0]     pieces_inc_s;
    logic [LEN_W-1:0]   step_inc_s;

    function automatic logic [3:0] rotate_phase(input logic [3:0] ph);
        return {ph[2:0], ph[3]};
    endfunction

    assign pieces_inc_s = {1'b0, pieces_q} + (CNT_W + 1)'(1);
    assign step_inc_s   = step_q + LEN_W'(1);

    // Next-state and registered-output computation; abort overrides every transition.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        num_d    = num_q;
        pieces_d = pieces_q;
        div_d    = div_q;
        step_d   = step_q;
        tmo_d    = tmo_q;
        phase_d  = phase_q;
        cut_d    = cut_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        if (abort_i) begin
            state_d = S_IDLE;
            cut_d   = 1'b0;
            phase_d = 4'b0000;
            busy_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_ERR: begin
                    if (start_i) begin
                        len_d    = len_i;
                        num_d    = num_i;
                        pieces_d = {CNT_W{1'b0}};
                        err_d    = 1'b0;
                        div_d    = {DIV_W{1'b0}};
                        step_d   = {LEN_W{1'b0}};
                        if (num_i == {CNT_W{1'b0}}) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else if (len_i == {LEN_W{1'b0}}) begin
                            state_d = S_CUT;
                            cut_d   = 1'b1;
                            tmo_d   = {TMO_W{1'b0}};
                            busy_d  = 1'b1;
                        end else begin
                            state_d = S_FEED;
                            phase_d = PHASE_FIRST;
                            busy_d  = 1'b1;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                S_FEED: begin
                    if (div_q == DIV_LAST) begin
                        div_d  = {DIV_W{1'b0}};
                        step_d = step_inc_s;
                        if (step_inc_s == len_q) begin
                            state_d = S_CUT;
                            phase_d = 4'b0000;
                            cut_d   = 1'b1;
                            tmo_d   = {TMO_W{1'b0}};
                        end else begin
                            phase_d = rotate_phase(phase_q);
                        end
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                S_CUT: begin
                    if (tmo_q == TMO_LAST) begin
                        state_d = S_ERR;
                        cut_d   = 1'b0;
                        phase_d = 4'b0000;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                    end else if (cut_end_i) begin
                        tmo_d   = tmo_q + TMO_W'(1);
                        state_d = S_CUT_REL;
                        cut_d   = 1'b0;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                S_CUT_REL: begin
                    if (tmo_q == TMO_LAST) begin
                        state_d = S_ERR;
                        cut_d   = 1'b0;
                        phase_d = 4'b0000;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                    end else if (!cut_end_i) begin
                        pieces_d = (pieces_q == num_q) ? pieces_q : pieces_inc_s[CNT_W-1:0];
                        if (pieces_inc_s == {1'b0, num_q}) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else if (len_q == {LEN_W{1'b0}}) begin
                            state_d = S_CUT;
                            cut_d   = 1'b1;
                            tmo_d   = {TMO_W{1'b0}};
                        end else begin
                            state_d = S_FEED;
                            phase_d = PHASE_FIRST;
                            div_d   = {DIV_W{1'b0}};
                            step_d  = {LEN_W{1'b0}};
                        end
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    cut_d   = 1'b0;
                    phase_d = 4'b0000;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            len_q    <= {LEN_W{1'b0}};
            num_q    <= {CNT_W{1'b0}};
            pieces_q <= {CNT_W{1'b0}};
            div_q    <= {DIV_W{1'b0}};
            step_q   <= {LEN_W{1'b0}};
            tmo_q    <= {TMO_W{1'b0}};
            phase_q  <= 4'b0000;
            cut_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            num_q    <= num_d;
            pieces_q <= pieces_d;
            div_q    <= div_d;
            step_q   <= step_d;
            tmo_q    <= tmo_d;
            phase_q  <= phase_d;
            cut_q    <= cut_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign pieces_o     = pieces_q;
    assign feed_phase_o = phase_q;
    assign cut_o        = cut_q;

endmodule

// File: tb/tb_cut_sequencer.sv
// Directed bench for cut_sequencer with STEP_PERIOD=4 and CUT_TIMEOUT=64.
module tb_cut_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [15:0] len_i;
    logic [7:0]  num_i;
    logic        abort_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [7:0]  pieces_o;
    logic [3:0]  feed_phase_o;
    logic        cut_o;
    logic        cut_end_i;

    int n_assert = 0;
    int n_fail   = 0;

    cut_sequencer #(
        .STEP_PERIOD(4),
        .LEN_W      (16),
        .CNT_W      (8),
        .CUT_TIMEOUT(64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .len_i       (len_i),
        .num_i       (num_i),
        .abort_i     (abort_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .pieces_o    (pieces_o),
        .feed_phase_o(feed_phase_o),
        .cut_o       (cut_o),
        .cut_end_i   (cut_end_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic [7:0] pcs);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_cut"}, 32'(cut_o), 32'd0);
        chk({tag, "_phase"}, 32'(feed_phase_o), 32'd0);
        chk({tag, "_pieces"}, 32'(pieces_o), 32'(pcs));
    endtask

    initial begin
        rst       = 1'b1;
        start_i   = 1'b0;
        len_i     = 16'd0;
        num_i     = 8'd0;
        abort_i   = 1'b0;
        cut_end_i = 1'b0;
        tick();
        tick();
        chk_idle("reset", 8'd0);
        chk("reset_done", 32'(done_o), 32'd0);
        chk("reset_err", 32'(err_o), 32'd0);
        rst = 1'b0;
        tick();

        // len=3, num=2, one-cycle cut_end pulse
        len_i = 16'd3; num_i = 8'd2; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("t1_busy_start", 32'(busy_o), 32'd1);
        for (int p = 1; p <= 2; p++) begin
            for (int i = 0; i < 12; i++) begin
                chk("t1_feed_phase", 32'(feed_phase_o), 32'(1 << (i / 4)));
                chk("t1_feed_nocut", 32'(cut_o), 32'd0);
                tick();
            end
            chk("t1_cut_rise", 32'(cut_o), 32'd1);
            chk("t1_cut_phase", 32'(feed_phase_o), 32'd0);
            repeat (5) begin
                chk("t1_cut_hold", 32'(cut_o), 32'd1);
                tick();
            end
            cut_end_i = 1'b1;
            tick();
            cut_end_i = 1'b0;
            chk("t1_cut_drop", 32'(cut_o), 32'd0);
            chk("t1_rel_pieces", 32'(pieces_o), 32'(p - 1));
            tick();
            chk("t1_pieces", 32'(pieces_o), 32'(p));
            chk("t1_done", 32'(done_o), 32'(p == 2));
            chk("t1_busy", 32'(busy_o), 32'(p == 1));
        end
        tick();
        chk("t1_done_once", 32'(done_o), 32'd0);
        chk_idle("t1_after", 8'd2);

        // num=0: immediate completion
        len_i = 16'd5; num_i = 8'd0; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("t2_done", 32'(done_o), 32'd1);
        chk_idle("t2_start", 8'd0);
        tick();
        chk("t2_done_end", 32'(done_o), 32'd0);
        chk_idle("t2_after", 8'd0);

        // len=0, num=3, cut_end level high 3 cycles per cut
        len_i = 16'd0; num_i = 8'd3; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int p = 1; p <= 3; p++) begin
            chk("t3_cut_on", 32'(cut_o), 32'd1);
            chk("t3_busy", 32'(busy_o), 32'd1);
            cut_end_i = 1'b1;
            repeat (3) begin
                tick();
                chk("t3_cut_off_while_end", 32'(cut_o), 32'd0);
                chk("t3_no_feed", 32'(feed_phase_o), 32'd0);
            end
            cut_end_i = 1'b0;
            tick();
            chk("t3_pieces", 32'(pieces_o), 32'(p));
            chk("t3_done", 32'(done_o), 32'(p == 3));
        end
        chk("t3_cut_final", 32'(cut_o), 32'd0);
        tick();
        chk_idle("t3_after", 8'd3);

        // cut handshake timeout
        len_i = 16'd0; num_i = 8'd1; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 64; i++) begin
            chk("t4_cut_wait", 32'(cut_o), 32'd1);
            chk("t4_no_err", 32'(err_o), 32'd0);
            tick();
        end
        chk("t4_err", 32'(err_o), 32'd1);
        chk_idle("t4_err", 8'd0);
        tick();
        chk("t4_err_held", 32'(err_o), 32'd1);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("t4_err_cleared", 32'(err_o), 32'd0);
        chk("t4_restart_cut", 32'(cut_o), 32'd1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk_idle("t4_abort", 8'd0);

        // abort during FEED step 2 of piece 1
        len_i = 16'd3; num_i = 8'd3; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (5) tick();
        chk("t5_phase_step2", 32'(feed_phase_o), 32'h2);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk_idle("t5_abort", 8'd0);
        chk("t5_no_done", 32'(done_o), 32'd0);
        tick();
        chk("t5_no_done_late", 32'(done_o), 32'd0);
        chk_idle("t5_after", 8'd0);

        // simultaneous start and abort in IDLE
        len_i = 16'd1; num_i = 8'd1; start_i = 1'b1; abort_i = 1'b1;
        tick();
        start_i = 1'b0; abort_i = 1'b0;
        chk_idle("t6_start_abort", 8'd0);
        chk("t6_no_done", 32'(done_o), 32'd0);

        // restart during job ignored, rst during CUT
        len_i = 16'd1; num_i = 8'd2; start_i = 1'b1;
        tick();
        len_i = 16'd7; num_i = 8'd9;
        tick();
        start_i = 1'b0;
        chk("t7_phase", 32'(feed_phase_o), 32'h1);
        repeat (3) tick();
        chk("t7_cut_len1", 32'(cut_o), 32'd1);
        chk("t7_busy", 32'(busy_o), 32'd1);
        rst = 1'b1;
        tick();
        chk_idle("t7_rst", 8'd0);
        chk("t7_rst_err", 32'(err_o), 32'd0);
        chk("t7_rst_done", 32'(done_o), 32'd0);
        rst = 1'b0;
        tick();
        chk_idle("t7_after", 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
